// File: rtl/bool1b_pkg.sv
// Shared types and constants for the 3-input Boolean evaluation unit.
// Index, one-hot and truth-table widths are all derived from the operand count.
package bool1b_pkg;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned ONEHOT_W = 1 << IDX_W;

  localparam logic [ONEHOT_W-1:0] BOOL1B_TT_DEFAULT = 8'hEA;

  typedef logic [IDX_W-1:0]    idx3_t;
  typedef logic [ONEHOT_W-1:0] onehot8_t;

endpackage : bool1b_pkg

// File: rtl/bool1b_if.sv
// Level-signal bundle between the operand source and the Boolean unit.
// The master drives operands a/b/c; the slave returns e and the minterm m.
interface bool1b_if;
  import bool1b_pkg::*;

  logic     a;
  logic     b;
  logic     c;
  logic     e;
  onehot8_t m;

  modport master (
    output a,
    output b,
    output c,
    input  e,
    input  m
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output e,
    output m
  );

endinterface : bool1b_if

// File: rtl/bool1b_dec3.sv
// Purely combinational 3-to-8 one-hot decoder.
// Exactly one output bit is set for any known index.
module bool1b_dec3
  import bool1b_pkg::*;
(
  input  idx3_t    idx_i,
  output onehot8_t onehot_c
);

  always_comb begin
    onehot_c        = '0;
    onehot_c[idx_i] = 1'b1;
  end

endmodule : bool1b_dec3

// File: rtl/bool1b_unit.sv
// Registered 3-input Boolean function e = F(a,b,c) defined by TRUTH_TABLE.
// Also registers the one-hot minterm of the sampled operands.
module bool1b_unit
  import bool1b_pkg::*;
#(
  parameter logic [ONEHOT_W-1:0] TRUTH_TABLE = BOOL1B_TT_DEFAULT
)(
  input  logic     clk,
  input  logic     rst,
  bool1b_if.slave  bus
);

  idx3_t    idx_c;
  onehot8_t m_next_c;
  logic     e_d;
  onehot8_t m_d;
  logic     e_q;
  onehot8_t m_q;

  assign idx_c = {bus.a, bus.b, bus.c};

  bool1b_dec3 u_dec3 (
    .idx_i    (idx_c),
    .onehot_c (m_next_c)
  );

  // The selected minterm masks the truth table; the OR picks out F(idx).
  always_comb begin
    e_d = 1'b0;
    m_d = '0;
    e_d = |(m_next_c & TRUTH_TABLE);
    m_d = m_next_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 1'b0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  assign bus.e = e_q;
  assign bus.m = m_q;

endmodule : bool1b_unit

// File: tb/tb_bool1b_unit.sv
// Scoreboard bench for bool1b_unit: default-table and XOR-table instances
// receive identical operands; a monitor checks both one cycle later.
module tb_bool1b_unit;
  import bool1b_pkg::*;

  typedef struct {
    logic       e_def;
    logic       e_xor;
    logic [7:0] m;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  bool1b_if if_def ();
  bool1b_if if_xor ();

  bool1b_unit u_def (
    .clk (clk),
    .rst (rst),
    .bus (if_def)
  );

  bool1b_unit #(.TRUTH_TABLE(8'h96)) u_xor (
    .clk (clk),
    .rst (rst),
    .bus (if_xor)
  );

  always #5 clk = ~clk;

  // Hand-derived reference: default is (a&b)|c, override is a^b^c.
  function automatic exp_t calc(input logic r, input logic [2:0] v);
    exp_t x;
    if (r) begin
      x.e_def = 1'b0;
      x.e_xor = 1'b0;
      x.m     = 8'h00;
    end else begin
      x.e_def = (v[2] & v[1]) | v[0];
      x.e_xor = v[2] ^ v[1] ^ v[0];
      case (v)
        3'd0:    x.m = 8'h01;
        3'd1:    x.m = 8'h02;
        3'd2:    x.m = 8'h04;
        3'd3:    x.m = 8'h08;
        3'd4:    x.m = 8'h10;
        3'd5:    x.m = 8'h20;
        3'd6:    x.m = 8'h40;
        default: x.m = 8'h80;
      endcase
    end
    return x;
  endfunction

  task automatic drive_ops(input logic [2:0] v);
    if_def.a = v[2]; if_def.b = v[1]; if_def.c = v[0];
    if_xor.a = v[2]; if_xor.b = v[1]; if_xor.c = v[0];
  endtask

  task automatic step(input logic r, input logic [2:0] v);
    @(negedge clk);
    rst = r;
    drive_ops(v);
    sb.push_back(calc(r, v));
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so pop one entry per edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("e_default", 8'(if_def.e), 8'(x.e_def));
        chk("e_xor",     8'(if_xor.e), 8'(x.e_xor));
        chk("m_default", if_def.m,     x.m);
        chk("m_xor",     if_xor.m,     x.m);
      end
    end
  end

  initial begin
    logic [2:0] v;
    rst = 1'b1;
    drive_ops(3'b111);
    #1;

    // Reset held with all operands high, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b111);
    step(1'b0, 3'b111);

    // a toggles every cycle, b every 2, c every 3: all eight indices.
    for (int t = 0; t < 12; t++) begin
      v = {1'(t % 2), 1'((t / 2) % 2), 1'((t / 3) % 2)};
      step(1'b0, v);
    end

    step(1'b0, 3'b110);
    step(1'b0, 3'b100);

    // Mid-cycle pulse on a must not be captured.
    step(1'b0, 3'b010);
    @(posedge clk);
    #2 if_def.a = 1'b1; if_xor.a = 1'b1;
    #5 if_def.a = 1'b0; if_xor.a = 1'b0;
    sb.push_back(calc(1'b0, 3'b010));

    // Single-cycle reset mid-sweep with 111 applied.
    step(1'b0, 3'b011);
    step(1'b1, 3'b111);
    step(1'b0, 3'b111);
    for (int i = 0; i < 8; i++) step(1'b0, 3'(i));

    // Drain with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bool1b_unit
